// File: rtl/key_pulse_conditioner_if.sv
// Key conditioner bundle: raw KEY pins and repeat enables in,
// debounced level and press/release pulses out.
interface key_pulse_conditioner_if #(
   parameter int NKEYS = 4
);
   logic [NKEYS-1:0] KEY;
   logic [NKEYS-1:0] repeat_en;
   logic [NKEYS-1:0] pressed;
   logic [NKEYS-1:0] press_pulse;
   logic [NKEYS-1:0] release_pulse;

   modport master (
      output KEY,
      output repeat_en,
      input  pressed,
      input  press_pulse,
      input  release_pulse
   );

   modport slave (
      input  KEY,
      input  repeat_en,
      output pressed,
      output press_pulse,
      output release_pulse
   );
endinterface

// File: rtl/key_pulse_conditioner.sv
// Pushbutton front end: 2-FF sync, per-key debounce, press/release
// pulses and auto-repeat press ticks while a key is held.
module key_pulse_conditioner #(
   parameter int NKEYS        = 4,
   parameter int DEBOUNCE_CYC = 500_000,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input logic                    clk,
   input logic                    reset_n,
   key_pulse_conditioner_if.slave kif
);

   localparam int DEB_W   = $clog2(DEBOUNCE_CYC);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                            REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX);

   localparam logic [DEB_W-1:0] DEB_TERM =
      DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [RPT_W-1:0] DLY_TERM =
      RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_TERM =
      RPT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } state_t;

   logic [NKEYS-1:0] sync1;
   logic [NKEYS-1:0] sync2;
   logic [NKEYS-1:0] stable;
   logic [NKEYS-1:0] deb_hit;
   logic [NKEYS-1:0] fall_ev;
   logic [NKEYS-1:0] rise_ev;
   logic [NKEYS-1:0] pressed_q;
   logic [NKEYS-1:0] press_q;
   logic [NKEYS-1:0] release_q;
   logic [NKEYS-1:0] press_d;
   logic [NKEYS-1:0] release_d;

   logic [DEB_W-1:0] deb_cnt   [NKEYS];
   logic [RPT_W-1:0] rpt_cnt_q [NKEYS];
   logic [RPT_W-1:0] rpt_cnt_d [NKEYS];
   state_t           state_q   [NKEYS];
   state_t           state_d   [NKEYS];

   // Released level is 1, so reset preloads the synchroniser high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= kif.KEY;
         sync2 <= sync1;
      end
   end

   always_comb begin
      deb_hit = '0;
      for (int k = 0; k < NKEYS; k++) begin
         deb_hit[k] = (sync2[k] != stable[k]) &&
                      (deb_cnt[k] == DEB_TERM);
      end
   end

   assign fall_ev = deb_hit & stable;
   assign rise_ev = deb_hit & ~stable;

   // pressed tracks the updated stable level, aligned with the pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable    <= '1;
         pressed_q <= '0;
         for (int k = 0; k < NKEYS; k++) begin
            deb_cnt[k] <= '0;
         end
      end else begin
         stable    <= stable ^ deb_hit;
         pressed_q <= ~(stable ^ deb_hit);
         for (int k = 0; k < NKEYS; k++) begin
            if (sync2[k] == stable[k] || deb_hit[k]) begin
               deb_cnt[k] <= '0;
            end else begin
               deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         press_q   <= '0;
         release_q <= '0;
         for (int k = 0; k < NKEYS; k++) begin
            state_q[k]   <= IDLE;
            rpt_cnt_q[k] <= '0;
         end
      end else begin
         press_q   <= press_d;
         release_q <= release_d;
         for (int k = 0; k < NKEYS; k++) begin
            state_q[k]   <= state_d[k];
            rpt_cnt_q[k] <= rpt_cnt_d[k];
         end
      end
   end

   // Release is tested first so it always beats a repeat terminal count
   always_comb begin
      press_d   = '0;
      release_d = '0;
      for (int k = 0; k < NKEYS; k++) begin
         state_d[k]   = state_q[k];
         rpt_cnt_d[k] = rpt_cnt_q[k];
         if (rise_ev[k]) begin
            release_d[k] = 1'b1;
            rpt_cnt_d[k] = '0;
            state_d[k]   = IDLE;
         end else begin
            unique case (state_q[k])
               IDLE: begin
                  if (fall_ev[k]) begin
                     press_d[k]   = 1'b1;
                     rpt_cnt_d[k] = '0;
                     state_d[k]   = DELAY;
                  end
               end
               DELAY: begin
                  if (!kif.repeat_en[k]) begin
                     rpt_cnt_d[k] = '0;
                  end else if (rpt_cnt_q[k] == DLY_TERM) begin
                     press_d[k]   = 1'b1;
                     rpt_cnt_d[k] = '0;
                     state_d[k]   = REPEAT;
                  end else begin
                     rpt_cnt_d[k] = rpt_cnt_q[k] + RPT_W'(1);
                  end
               end
               REPEAT: begin
                  if (!kif.repeat_en[k]) begin
                     rpt_cnt_d[k] = '0;
                     state_d[k]   = DELAY;
                  end else if (rpt_cnt_q[k] == RATE_TERM) begin
                     press_d[k]   = 1'b1;
                     rpt_cnt_d[k] = '0;
                  end else begin
                     rpt_cnt_d[k] = rpt_cnt_q[k] + RPT_W'(1);
                  end
               end
               default: begin
                  rpt_cnt_d[k] = '0;
                  state_d[k]   = IDLE;
               end
            endcase
         end
      end
   end

   assign kif.pressed       = pressed_q;
   assign kif.press_pulse   = press_q;
   assign kif.release_pulse = release_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with short sim timings
// (debounce 4, repeat delay 10, repeat rate 3).
module tb_key_pulse_conditioner;

   localparam int NK = 4;

   logic clk = 1'b0;
   logic reset_n;

   key_pulse_conditioner_if #(.NKEYS(NK)) kif ();

   key_pulse_conditioner #(
      .NKEYS        (NK),
      .DEBOUNCE_CYC (4),
      .REPEAT_DELAY (10),
      .REPEAT_RATE  (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kif     (kif)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int press_cnt [NK];
   int rel_cnt   [NK];
   int both_err;
   int p2_t      [4];
   int p2_n;
   logic [NK-1:0] pressed_seen;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NK; k++) begin
         press_cnt[k] = 0;
         rel_cnt[k]   = 0;
      end
      for (int i = 0; i < 4; i++) p2_t[i] = -1;
      p2_n         = 0;
      both_err     = 0;
      pressed_seen = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      pressed_seen = pressed_seen | kif.pressed;
      for (int k = 0; k < NK; k++) begin
         if (kif.press_pulse[k]) press_cnt[k]++;
         if (kif.release_pulse[k]) rel_cnt[k]++;
         if (kif.press_pulse[k] && kif.release_pulse[k]) both_err++;
      end
      if (kif.press_pulse[2]) begin
         if (p2_n < 4) p2_t[p2_n] = cyc;
         p2_n++;
      end
   endtask

   int base;

   initial begin
      kif.KEY       = '1;
      kif.repeat_en = '0;
      reset_n       = 1'b0;
      clear_counts();
      repeat (3) tick();
      chk("rst_pressed", 32'(kif.pressed), 0);
      chk("rst_press",   32'(kif.press_pulse), 0);
      chk("rst_release", 32'(kif.release_pulse), 0);
      reset_n = 1'b1;
      repeat (3) tick();
      chk("idle_pressed", 32'(kif.pressed), 0);

      // A: key0 held 30 cycles, no auto-repeat
      clear_counts();
      kif.KEY[0] = 1'b0;
      repeat (5) tick();
      chk("a_before", 32'(kif.pressed), 0);
      tick();
      chk("a_pressed", 32'(kif.pressed), 32'b0001);
      chk("a_pulse", 32'(kif.press_pulse), 32'b0001);
      repeat (24) tick();
      chk("a_one_press", press_cnt[0], 1);
      kif.KEY[0] = 1'b1;
      repeat (5) tick();
      chk("a_still_held", 32'(kif.pressed), 32'b0001);
      tick();
      chk("a_rel_pulse", 32'(kif.release_pulse), 32'b0001);
      chk("a_released", 32'(kif.pressed), 0);
      repeat (3) tick();
      chk("a_one_rel", rel_cnt[0], 1);
      chk("a_press_total", press_cnt[0], 1);

      // B: 3-cycle glitch on key1 is filtered
      clear_counts();
      kif.KEY[1] = 1'b0;
      repeat (3) tick();
      kif.KEY[1] = 1'b1;
      repeat (10) tick();
      chk("b_press", press_cnt[1], 0);
      chk("b_rel", rel_cnt[1], 0);
      chk("b_level", 32'(pressed_seen), 0);

      // C: bounce 0,1,0,1 on key3 then held low
      clear_counts();
      kif.KEY[3] = 1'b0; tick();
      kif.KEY[3] = 1'b1; tick();
      kif.KEY[3] = 1'b0; tick();
      kif.KEY[3] = 1'b1; tick();
      kif.KEY[3] = 1'b0;
      repeat (5) tick();
      chk("c_early", press_cnt[3], 0);
      tick();
      chk("c_pulse", 32'(kif.press_pulse), 32'b1000);
      repeat (10) tick();
      chk("c_one_press", press_cnt[3], 1);
      kif.KEY[3] = 1'b1;
      repeat (10) tick();
      chk("c_one_rel", rel_cnt[3], 1);

      // D: key2 held 40 cycles with auto-repeat
      clear_counts();
      kif.repeat_en[2] = 1'b1;
      kif.KEY[2]       = 1'b0;
      base = cyc;
      repeat (40) tick();
      chk("d_press_cnt", press_cnt[2], 10);
      chk("d_t0", p2_t[0] - base, 6);
      chk("d_t1", p2_t[1] - base, 16);
      chk("d_t2", p2_t[2] - base, 19);
      chk("d_t3", p2_t[3] - base, 22);
      kif.KEY[2] = 1'b1;
      repeat (5) tick();
      tick();
      chk("d_rel_wins", 32'(kif.release_pulse[2]), 1);
      chk("d_no_press", 32'(kif.press_pulse[2]), 0);
      repeat (10) tick();
      chk("d_press_total", press_cnt[2], 11);
      chk("d_rel_total", rel_cnt[2], 1);
      chk("d_exclusive", both_err, 0);

      // E: reset asserted mid-REPEAT with key2 held
      kif.KEY[2] = 1'b0;
      repeat (20) tick();
      chk("e_held", 32'(kif.pressed), 32'b0100);
      clear_counts();
      reset_n = 1'b0;
      #1;
      chk("e_rst_pressed", 32'(kif.pressed), 0);
      chk("e_rst_press", 32'(kif.press_pulse), 0);
      chk("e_rst_rel", 32'(kif.release_pulse), 0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      chk("e_no_pulse", press_cnt[2] + rel_cnt[2], 0);
      tick();
      chk("e_fresh", 32'(kif.press_pulse), 32'b0100);
      kif.repeat_en[2] = 1'b0;
      kif.KEY[2]       = 1'b1;
      repeat (10) tick();
      chk("e_rel", rel_cnt[2], 1);
      chk("e_press", press_cnt[2], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
